// File: rtl/pong_score_keeper.sv
// pong_score_keeper: goal detection, scoring and the serve/play/game-over sequencer
// sitting between pong_logic (ball position in) and pong_renderer (scores out).
// Everything runs in the clk_0 pixel-clock domain; goals are judged once per frame.
//
// Ports:
//   clk_0        pixel clock
//   rst          synchronous reset, active-low
//   frame_tick   one-cycle pulse per frame (start of vertical blank)
//   start        debounced start button, level, active-high
//   sq_xpos      ball left-edge x coordinate
//   play_enable  high only while the ball is in play
//   ball_reset   one-cycle pulse asking pong_logic to recentre the ball
//   serve_dir    0 = serve toward player 1 (left), 1 = toward player 2 (right)
//   score_p1/p2  player scores, binary
//   game_over    high once a player has reached WIN_SCORE
//   winner       0 = player 1, 1 = player 2; valid while game_over is high
//   goal_pulse   one-cycle pulse on every goal
module pong_score_keeper #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SQ_SIZE      = 10,
  parameter int unsigned LEFT_GOAL_X  = 0,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] sq_xpos,
  output logic       play_enable,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic       goal_pulse
);

  localparam int unsigned XW = 11;  // one bit wider than sq_xpos so x + SQ_SIZE cannot wrap
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t        state;
  logic [CW-1:0] serve_cnt;

  logic [XW-1:0] x_ext_c;
  logic          left_goal_c;
  logic          right_goal_c;
  logic          serve_last_c;
  logic [SW-1:0] p1_inc_c;
  logic [SW-1:0] p2_inc_c;

  // Goal geometry and score increments, evaluated every cycle, used only in PLAY.
  assign x_ext_c      = XW'(sq_xpos);
  assign left_goal_c  = x_ext_c <= XW'(LEFT_GOAL_X);
  assign right_goal_c = (x_ext_c + XW'(SQ_SIZE)) >= XW'(SCREEN_W);
  assign serve_last_c = serve_cnt == CW'(SERVE_FRAMES - 1);
  assign p1_inc_c     = score_p1 + SW'(1);
  assign p2_inc_c     = score_p2 + SW'(1);

  // Sequencer with registered outputs.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state       <= IDLE;
      serve_cnt   <= '0;
      play_enable <= 1'b0;
      ball_reset  <= 1'b0;
      serve_dir   <= 1'b0;
      score_p1    <= '0;
      score_p2    <= '0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      goal_pulse  <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      goal_pulse <= 1'b0;
      case (state)
        IDLE: begin
          play_enable <= 1'b0;
          if (start) begin
            state      <= SERVE;
            ball_reset <= 1'b1;
            serve_cnt  <= '0;
            serve_dir  <= 1'b0;
          end
        end
        SERVE: begin
          play_enable <= 1'b0;
          if (frame_tick) begin
            if (serve_last_c) begin
              state       <= PLAY;
              serve_cnt   <= '0;
              play_enable <= 1'b1;
            end else begin
              serve_cnt <= serve_cnt + CW'(1);
            end
          end
        end
        PLAY: begin
          // Left goal wins a tie so only one point is ever awarded per frame.
          if (frame_tick && (left_goal_c || right_goal_c)) begin
            goal_pulse  <= 1'b1;
            ball_reset  <= 1'b1;
            play_enable <= 1'b0;
            serve_cnt   <= '0;
            if (left_goal_c) begin
              score_p2  <= p2_inc_c;
              serve_dir <= 1'b0;
              if (p2_inc_c == SW'(WIN_SCORE)) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b1;
              end else begin
                state <= SERVE;
              end
            end else begin
              score_p1  <= p1_inc_c;
              serve_dir <= 1'b1;
              if (p1_inc_c == SW'(WIN_SCORE)) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b0;
              end else begin
                state <= SERVE;
              end
            end
          end
        end
        OVER: begin
          play_enable <= 1'b0;
          if (start) begin
            state      <= SERVE;
            score_p1   <= '0;
            score_p2   <= '0;
            winner     <= 1'b0;
            game_over  <= 1'b0;
            ball_reset <= 1'b1;
            serve_dir  <= 1'b0;
            serve_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Randomized bench for pong_score_keeper against a behavioural game model.
module tb_pong_score_keeper;

  localparam int SCREEN_W     = 640;
  localparam int SQ_SIZE      = 10;
  localparam int LEFT_GOAL_X  = 0;
  localparam int WIN_SCORE    = 7;
  localparam int SERVE_FRAMES = 60;
  localparam int N_CYCLES     = 20000;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] sq_xpos = '0;
  logic       play_enable, ball_reset, serve_dir, game_over, winner, goal_pulse;
  logic [3:0] score_p1, score_p2;

  pong_score_keeper dut (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .start(start), .sq_xpos(sq_xpos),
    .play_enable(play_enable), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over), .winner(winner),
    .goal_pulse(goal_pulse)
  );

  always #5 clk_0 = ~clk_0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Game model: a game is either not started, finished, counting down frames
  // before a serve, or live. Expected outputs are what should appear after the edge.
  bit m_started, m_over;
  int m_frames_left;
  int m_p1, m_p2;
  bit e_play, e_reset, e_dir, e_over, e_winner, e_goal;
  int n_goals = 0, n_games = 0, n_restarts = 0;

  task automatic model_step(input bit r, input bit st, input bit tk, input int x);
    e_reset = 1'b0;
    e_goal  = 1'b0;
    if (!r) begin
      m_started = 0; m_over = 0; m_frames_left = 0; m_p1 = 0; m_p2 = 0;
      e_play = 0; e_dir = 0; e_over = 0; e_winner = 0;
    end else if (!m_started || m_over) begin
      if (st) begin
        if (m_over) n_restarts++;
        m_started = 1; m_over = 0; m_p1 = 0; m_p2 = 0;
        m_frames_left = SERVE_FRAMES;
        e_over = 0; e_winner = 0; e_dir = 0; e_reset = 1; e_play = 0;
      end
    end else if (m_frames_left > 0) begin
      if (tk) begin
        m_frames_left--;
        if (m_frames_left == 0) e_play = 1;
      end
    end else if (tk) begin
      bit left_hit, right_hit;
      left_hit  = (x <= LEFT_GOAL_X);
      right_hit = (x + SQ_SIZE >= SCREEN_W);
      if (left_hit || right_hit) begin
        n_goals++;
        e_goal = 1; e_reset = 1; e_play = 0;
        if (left_hit) begin
          m_p2++; e_dir = 0;
          if (m_p2 == WIN_SCORE) begin m_over = 1; e_over = 1; e_winner = 1; end
        end else begin
          m_p1++; e_dir = 1;
          if (m_p1 == WIN_SCORE) begin m_over = 1; e_over = 1; e_winner = 0; end
        end
        if (m_over) n_games++;
        else m_frames_left = SERVE_FRAMES;
      end
    end
  endtask

  task automatic check_all();
    check("play_enable", 16'(play_enable), 16'(e_play));
    check("ball_reset",  16'(ball_reset),  16'(e_reset));
    check("goal_pulse",  16'(goal_pulse),  16'(e_goal));
    check("serve_dir",   16'(serve_dir),   16'(e_dir));
    check("score_p1",    16'(score_p1),    16'(m_p1));
    check("score_p2",    16'(score_p2),    16'(m_p2));
    check("game_over",   16'(game_over),   16'(e_over));
    check("winner",      16'(winner),      16'(e_winner));
  endtask

  // Ball positions biased toward goal boundaries and the 10-bit top end.
  function automatic int pick_x();
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0: return 0;
      1: return 1;
      2: return 629;
      3: return 630;
      4: return 635;
      5: return 1023;
      default: return int'($urandom_range(1, 629));
    endcase
  endfunction

  initial begin
    int  held_mode;
    bit  r, st, tk;
    int  x;

    // Reset for a few cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_0);
      rst = 1'b0; start = 1'b1; frame_tick = 1'b1; sq_xpos = 10'd0;
      model_step(1'b0, 1'b1, 1'b1, 0);
      @(posedge clk_0); #1;
      check_all();
    end

    held_mode = 0;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      if (cyc % 250 == 0) held_mode = int'($urandom_range(0, 2));
      @(negedge clk_0);
      r  = ($urandom_range(0, 999) != 0);
      st = (held_mode == 2) ? 1'b1 : ($urandom_range(0, 15) == 0);
      tk = ($urandom_range(0, 1) == 0);
      x  = pick_x();
      rst = r; start = st; frame_tick = tk; sq_xpos = 10'(x);
      model_step(r, st, tk, x);
      @(posedge clk_0); #1;
      check_all();
    end

    // The random run must actually have exercised goals, wins and restarts.
    check("goals_seen",    16'(n_goals > 20), 16'd1);
    check("games_won",     16'(n_games > 0),  16'd1);
    check("restarts_seen", 16'(n_restarts > 0), 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
